// File: rtl/bcd_to_bin.sv
// bcd_to_bin: iterative reverse double-dabble converter from packed BCD to unsigned binary
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                state;
    logic [4*DIGITS-1:0]   bcd_q, bcd_nx;
    logic [BIN_W-1:0]      bin_q, bin_nx;
    logic [CW-1:0]         cnt;
    logic                  bad;

    // flag any operand digit outside 0..9
    always_comb begin
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++)
            bad = bad | (bcd_in[4*d +: 4] > 4'd9);
    end

    // one iteration: shift the pair right, then pull 3 out of every digit that reached 8 or more
    always_comb begin
        {bcd_nx, bin_nx} = {bcd_q, bin_q} >> 1;
        for (int d = 0; d < DIGITS; d++)
            bcd_nx[4*d +: 4] = (bcd_nx[4*d +: 4] >= 4'd8) ? bcd_nx[4*d +: 4] - 4'd3 : bcd_nx[4*d +: 4];
    end

    // handshake FSM with registered status outputs and the iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ready <= 1'b0;
                    if (bad) begin
                        err     <= 1'b1;
                        bin_out <= '0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        bcd_q <= bcd_in;
                        bin_q <= '0;
                        cnt   <= CW'(BIN_W);
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_nx;
                    bin_q <= bin_nx;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        bin_out <= bin_nx;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
